// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog
// Purpose  : Single-clock FIFO with occupancy count, programmable almost-full
//            and almost-empty thresholds, synchronous flush and pulsed
//            overflow/underflow. Define FIFO_FWFT_EN for first-word-fall-through
//            reads; the default build has a 1-cycle registered read.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr_enb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_enb,
    output logic [DATA_W-1:0] rd_data,
    input  logic [AW:0]       af_thresh,
    input  logic [AW:0]       ae_thresh,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              half,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] c_full_lvl = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_half_lvl = (AW+1)'(DEPTH / 2);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_wr_rej;
    logic w_rd_rej;

    assign w_full  = (r_count == c_full_lvl);
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is allowed when a read frees the slot this same edge.
    assign w_wr_acc = !clr && wr_enb && (!w_full || rd_enb);
    assign w_rd_acc = !clr && rd_enb && !w_empty;
    assign w_wr_rej = !clr && wr_enb && !w_wr_acc;
    assign w_rd_rej = !clr && rd_enb && w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_wr_rej;
            r_underflow <= w_rd_rej;
            if (clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_wr_acc, w_rd_acc})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is shown directly; the pop only advances the read pointer.
    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_data <= '0;
        end else if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    assign rd_data = r_rd_data;
`endif

    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign half         = (r_count >= c_half_lvl);
    assign almost_full  = (r_count >= af_thresh);
    assign almost_empty = (r_count <= ae_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_prog
// Purpose  : Directed self-checking bench for sync_fifo_prog (DATA_W=8,
//            DEPTH=16); FIFO_FWFT_EN selects the fall-through checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              clk;
    logic              rstn;
    logic              clr;
    logic              wr_enb;
    logic [DATA_W-1:0] wr_data;
    logic              rd_enb;
    logic [DATA_W-1:0] rd_data;
    logic [AW:0]       af_thresh;
    logic [AW:0]       ae_thresh;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              half;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    int n_total;
    int n_bad;

    sync_fifo_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (clr),
        .wr_enb       (wr_enb),
        .wr_data      (wr_data),
        .rd_enb       (rd_enb),
        .rd_data      (rd_data),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .half         (half),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_enb  = 1'b1;
        wr_data = d;
        cyc();
        wr_enb  = 1'b0;
    endtask

    task automatic pop();
        rd_enb = 1'b1;
        cyc();
        rd_enb = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rstn      = 1'b0;
        clr       = 1'b0;
        wr_enb    = 1'b0;
        wr_data   = '0;
        rd_enb    = 1'b0;
        af_thresh = 5'd14;
        ae_thresh = 5'd2;
        #3;
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full",  32'(full),  32'd0);
        check_val("rst_half",  32'(half),  32'd0);
        check_val("rst_ae",    32'(almost_empty), 32'd1);
        check_val("rst_af",    32'(almost_full),  32'd0);
        check_val("rst_rdata", 32'(rd_data), 32'd0);
        check_val("rst_ovf",   32'(overflow),  32'd0);
        check_val("rst_udf",   32'(underflow), 32'd0);
        cyc();
        rstn = 1'b1;
        cyc();

`ifndef FIFO_FWFT_EN
        // Test 1: fill with 0x00..0x0F, then drain in order
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            if (i == 6)  check_val("t1_half_at7", 32'(half), 32'd0);
            if (i == 7)  check_val("t1_half_at8", 32'(half), 32'd1);
            if (i == 14) check_val("t1_full_at15", 32'(full), 32'd0);
        end
        check_val("t1_full",  32'(full),  32'd1);
        check_val("t1_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            pop();
            check_val("t1_rdata", 32'(rd_data), 32'(i));
        end
        check_val("t1_empty", 32'(empty), 32'd1);
        cyc();
        check_val("t1_hold", 32'(rd_data), 32'h0F);

        // Test 2: overflow on a lone write to a full FIFO
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hAA);
        check_val("t2_ovf",   32'(overflow), 32'd1);
        check_val("t2_count", 32'(count), 32'd16);
        cyc();
        check_val("t2_ovf_end", 32'(overflow), 32'd0);
        pop();
        check_val("t2_rdata", 32'(rd_data), 32'h00);
        flush();

        // Test 3: read+write on an empty FIFO
        rd_enb  = 1'b1;
        wr_enb  = 1'b1;
        wr_data = 8'h55;
        cyc();
        rd_enb  = 1'b0;
        wr_enb  = 1'b0;
        check_val("t3_udf",   32'(underflow), 32'd1);
        check_val("t3_count", 32'(count), 32'd1);
        check_val("t3_rhold", 32'(rd_data), 32'h00);
        cyc();
        check_val("t3_udf_end", 32'(underflow), 32'd0);
        pop();
        check_val("t3_rdata", 32'(rd_data), 32'h55);
        check_val("t3_empty", 32'(empty), 32'd1);

        // Test 4: read+write on a full FIFO
        for (int i = 0; i < 16; i++) push(8'(i));
        rd_enb  = 1'b1;
        wr_enb  = 1'b1;
        wr_data = 8'h77;
        cyc();
        rd_enb  = 1'b0;
        wr_enb  = 1'b0;
        check_val("t4_ovf",   32'(overflow), 32'd0);
        check_val("t4_count", 32'(count), 32'd16);
        check_val("t4_rd0",   32'(rd_data), 32'h00);
        for (int i = 1; i < 16; i++) begin
            pop();
            check_val("t4_rdata", 32'(rd_data), 32'(i));
        end
        pop();
        check_val("t4_last", 32'(rd_data), 32'h77);
        check_val("t4_empty", 32'(empty), 32'd1);

        // Test 5: 20 writes/20 reads overlapped across the pointer wrap
        for (int i = 0; i < 3; i++) push(8'(8'h80 + i));
        for (int i = 0; i < 17; i++) begin
            wr_enb  = 1'b1;
            wr_data = 8'(8'h83 + i);
            rd_enb  = 1'b1;
            cyc();
            check_val("t5_rdata", 32'(rd_data), 32'(8'h80 + i));
            check_val("t5_count", 32'(count), 32'd3);
        end
        wr_enb = 1'b0;
        for (int i = 17; i < 20; i++) begin
            pop();
            check_val("t5_tail", 32'(rd_data), 32'(8'h80 + i));
        end
        check_val("t5_empty", 32'(empty), 32'd1);
        // flush at count 5 with both requests active
        for (int i = 0; i < 5; i++) push(8'(8'hB0 + i));
        check_val("t5_cnt5", 32'(count), 32'd5);
        clr     = 1'b1;
        wr_enb  = 1'b1;
        rd_enb  = 1'b1;
        cyc();
        clr     = 1'b0;
        wr_enb  = 1'b0;
        rd_enb  = 1'b0;
        check_val("t5_clr_count", 32'(count), 32'd0);
        check_val("t5_clr_empty", 32'(empty), 32'd1);
        check_val("t5_clr_ovf",   32'(overflow),  32'd0);
        check_val("t5_clr_udf",   32'(underflow), 32'd0);
        check_val("t5_clr_rhold", 32'(rd_data), 32'h93);
        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 4; i++) push(8'(8'hC1 + i));
        pop();
        check_val("t5_pre_rst", 32'(rd_data), 32'hC1);
        wr_enb  = 1'b1;
        wr_data = 8'hC5;
        cyc();
        #2;
        rstn = 1'b0;
        #1;
        check_val("t5_arst_count", 32'(count), 32'd0);
        check_val("t5_arst_rdata", 32'(rd_data), 32'h00);
        check_val("t5_arst_empty", 32'(empty), 32'd1);
        wr_enb = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();
        check_val("t5_post_rst", 32'(count), 32'd0);

        // Test 6: threshold sweep
        for (int c = 0; c <= 16; c++) begin
            check_val("t6_count", 32'(count), 32'(c));
            check_val("t6_ae", 32'(almost_empty), (c <= 2)  ? 32'd1 : 32'd0);
            check_val("t6_af", 32'(almost_full),  (c >= 14) ? 32'd1 : 32'd0);
            if (c == 5) begin
                af_thresh = 5'd4;
                #1;
                check_val("t6_af_lowered", 32'(almost_full), 32'd1);
                af_thresh = 5'd14;
                #1;
                check_val("t6_af_restored", 32'(almost_full), 32'd0);
                af_thresh = 5'd0;
                ae_thresh = 5'd16;
                #1;
                check_val("t6_af_zero", 32'(almost_full),  32'd1);
                check_val("t6_ae_max",  32'(almost_empty), 32'd1);
                af_thresh = 5'd14;
                ae_thresh = 5'd2;
            end
            if (c < 16) push(8'(c));
        end
        flush();
`else
        // FWFT: head word appears without a read request
        push(8'h3C);
        check_val("fw_rdata", 32'(rd_data), 32'h3C);
        check_val("fw_count", 32'(count), 32'd1);
        check_val("fw_empty0", 32'(empty), 32'd0);
        push(8'h4D);
        check_val("fw_head", 32'(rd_data), 32'h3C);
        pop();
        check_val("fw_next", 32'(rd_data), 32'h4D);
        pop();
        check_val("fw_empty", 32'(empty), 32'd1);
        check_val("fw_zero", 32'(rd_data), 32'h00);
        pop();
        check_val("fw_udf", 32'(underflow), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
